// File: rtl/pipe_collision_monitor.sv
// Single-pipe scroller with LFSR gap placement, pass scoring and bird collision detection.
// Feeds q_Lost and the VGA overlay from the bird physics FSM's YBird/XBird.
//
//  state  | meaning
//  -------+--------------------------------------------------
//  S_IDLE | pipe frozen, score held, waiting for Start
//  S_RUN  | pipe scrolls, score counts, collisions checked
//  S_LOST | everything frozen after a hit, waiting for Start
module pipe_collision_monitor #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int BIRD_SIZE  = 16,
  parameter int PIPE_W     = 60,
  parameter int GAP_H      = 120,
  parameter int GAP_MIN    = 40,
  parameter int GAP_INIT   = 180,
  parameter int SCROLL_DIV = 1000000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [9:0] YBird,
  input  logic [9:0] XBird,
  output logic [9:0] XPipe,
  output logic [9:0] YGapTop,
  output logic [7:0] Score,
  output logic       Lost,
  output logic       q_Idle,
  output logic       q_Run,
  output logic       q_Lost
);

  localparam int TW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_RUN  = 3'b010,
    S_LOST = 3'b100
  } state_t;

  state_t          state_q, state_d;
  logic [9:0]      xpipe_q, xpipe_d;
  logic [9:0]      ygap_q, ygap_d;
  logic [7:0]      score_q, score_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic [10:0] ybird_top, ybird_bot, xbird_l, xbird_r, xpipe_l, xpipe_r, gap_top, gap_bot;
  logic        out_of_bounds, x_overlap, y_outside_gap, hit, tick, pass;
  logic        lfsr_fb;

  // 11-bit extension keeps the sums exact; a wrapped (underflowed) YBird lands >= SCREEN_H
  assign ybird_top = {1'b0, YBird};
  assign ybird_bot = {1'b0, YBird} + 11'(BIRD_SIZE);
  assign xbird_l   = {1'b0, XBird};
  assign xbird_r   = {1'b0, XBird} + 11'(BIRD_SIZE);
  assign xpipe_l   = {1'b0, xpipe_q};
  assign xpipe_r   = {1'b0, xpipe_q} + 11'(PIPE_W);
  assign gap_top   = {1'b0, ygap_q};
  assign gap_bot   = {1'b0, ygap_q} + 11'(GAP_H);

  assign out_of_bounds = (ybird_top >= 11'(SCREEN_H)) || (ybird_bot >= 11'(SCREEN_H));
  assign x_overlap     = (xbird_r > xpipe_l) && (xbird_l < xpipe_r);
  assign y_outside_gap = (ybird_top < gap_top) || (ybird_bot > gap_bot);
  assign hit           = out_of_bounds || (x_overlap && y_outside_gap);

  assign tick    = (timer_q == TW'(SCROLL_DIV - 1));
  assign pass    = (xpipe_r == xbird_l);
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      xpipe_q <= 10'(SCREEN_W);
      ygap_q  <= 10'(GAP_INIT);
      score_q <= 8'd0;
      lfsr_q  <= 8'hA5;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      xpipe_q <= xpipe_d;
      ygap_q  <= ygap_d;
      score_q <= score_d;
      lfsr_q  <= lfsr_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    xpipe_d = xpipe_q;
    ygap_d  = ygap_q;
    score_d = score_q;
    lfsr_d  = lfsr_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_RUN;
          score_d = 8'd0;
          timer_d = '0;
          xpipe_d = 10'(SCREEN_W);
        end
      end
      S_RUN: begin
        lfsr_d = {lfsr_q[6:0], lfsr_fb};
        // a hit freezes the playfield on the edge it is taken
        if (hit) begin
          state_d = S_LOST;
        end else if (tick) begin
          timer_d = '0;
          if (xpipe_q == 10'd0) begin
            xpipe_d = 10'(SCREEN_W);
            ygap_d  = 10'(GAP_MIN) + {2'b00, lfsr_q};
          end else begin
            xpipe_d = xpipe_q - 10'd1;
          end
          if (pass && (score_q != 8'hFF))
            score_d = score_q + 8'd1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_LOST: begin
        if (Start)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign XPipe   = xpipe_q;
  assign YGapTop = ygap_q;
  assign Score   = score_q;
  assign q_Idle  = (state_q == S_IDLE);
  assign q_Run   = (state_q == S_RUN);
  assign q_Lost  = (state_q == S_LOST);
  assign Lost    = q_Lost;

endmodule

// File: tb/tb_pipe_collision_monitor.sv
// Directed bench for pipe_collision_monitor: reset, scrolling, wrap, scoring, collisions,
// state stepping; a narrow-screen second instance reaches score saturation quickly.
module tb_pipe_collision_monitor;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [9:0] ybird, xbird;
  logic [9:0] xpipe, ygap;
  logic [7:0] score;
  logic       lost, q_idle, q_run, q_lost;

  logic       rst_s, start_s;
  logic [9:0] ybird_s, xbird_s;
  logic [9:0] xpipe_s, ygap_s;
  logic [7:0] score_s;
  logic       lost_s, q_idle_s, q_run_s, q_lost_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_collision_monitor #(.SCROLL_DIV(4)) u_dut (
    .Clk(clk), .Reset(rst), .Start(start), .YBird(ybird), .XBird(xbird),
    .XPipe(xpipe), .YGapTop(ygap), .Score(score), .Lost(lost),
    .q_Idle(q_idle), .q_Run(q_run), .q_Lost(q_lost)
  );

  // pipe wraps every 9 ticks and the bird sits just past the respawn column, so it scores every pass
  pipe_collision_monitor #(.SCREEN_W(8), .PIPE_W(4), .SCROLL_DIV(2)) u_sat (
    .Clk(clk), .Reset(rst_s), .Start(start_s), .YBird(ybird_s), .XBird(xbird_s),
    .XPipe(xpipe_s), .YGapTop(ygap_s), .Score(score_s), .Lost(lost_s),
    .q_Idle(q_idle_s), .q_Run(q_run_s), .q_Lost(q_lost_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ybird = 10'd200; xbird = 10'd100;
    rst_s = 1'b1; start_s = 1'b0; ybird_s = 10'd200; xbird_s = 10'd12;
    step(2);
    rst = 1'b0; rst_s = 1'b0;
    check("rst_idle", q_idle, 1);
    check("rst_run", q_run, 0);
    check("rst_xpipe", xpipe, 640);
    check("rst_gap", ygap, 180);
    check("rst_score", score, 0);
    check("rst_lost", lost, 0);

    step(5);
    check("idle_frozen", xpipe, 640);

    start = 1'b1; step(1); start = 1'b0;
    check("start_run", q_run, 1);
    check("start_xpipe", xpipe, 640);
    step(3);
    check("pre_tick", xpipe, 640);
    step(1);
    check("first_tick", xpipe, 639);
    step(2556);
    check("xpipe_zero", xpipe, 0);
    check("score_first_pass", score, 1);
    check("no_lost_in_gap", lost, 0);
    step(3);
    check("zero_hold", xpipe, 0);
    step(1);
    check("wrap_xpipe", xpipe, 640);
    check("wrap_gap_range", (ygap >= 10'd40) && (ygap <= 10'd295), 1);

    rst = 1'b1; step(2); rst = 1'b0;
    check("midrun_rst_idle", q_idle, 1);
    check("midrun_rst_xpipe", xpipe, 640);
    check("midrun_rst_gap", ygap, 180);
    check("midrun_rst_score", score, 0);
    check("midrun_rst_lost", lost, 0);

    xbird = 10'd500; ybird = 10'd200;
    start = 1'b1; step(1); start = 1'b0;
    step(800);
    check("at_440_xpipe", xpipe, 440);
    check("at_440_score", score, 0);
    step(4);
    check("pass_xpipe", xpipe, 439);
    check("pass_score", score, 1);
    check("pass_no_lost", lost, 0);

    ybird = 10'd470; step(1);
    check("floor_lost", lost, 1);
    check("floor_qlost", q_lost, 1);
    check("floor_xpipe", xpipe, 439);
    step(5);
    check("lost_hold", lost, 1);
    check("lost_score_kept", score, 1);

    ybird = 10'd463;
    start = 1'b1; step(1);
    check("lost_to_idle", q_idle, 1);
    check("idle_lost_low", lost, 0);
    check("idle_score_kept", score, 1);
    step(1); start = 1'b0;
    check("idle_to_run", q_run, 1);
    check("run_score_clr", score, 0);
    check("run_xpipe", xpipe, 640);
    step(19);
    check("y463_no_lost", lost, 0);
    check("y463_xpipe", xpipe, 636);
    ybird = 10'd1020; step(1);
    check("wrap_y_lost", lost, 1);
    check("hit_tick_xpipe", xpipe, 636);

    ybird = 10'd100;
    start = 1'b1; step(1);
    check("t4_idle", q_idle, 1);
    step(1); start = 1'b0;
    check("t4_run", q_run, 1);
    check("t4_gap", ygap, 180);
    step(500);
    check("t4_xpipe_515", xpipe, 515);
    check("t4_still_run", q_run, 1);
    step(1);
    check("t4_lost", lost, 1);
    check("t4_qlost", q_lost, 1);
    check("t4_xpipe_frozen", xpipe, 515);
    step(8);
    check("t4_xpipe_hold", xpipe, 515);

    start_s = 1'b1; step(1); start_s = 1'b0;
    check("sat_run", q_run_s, 1);
    step(100);
    check("sat_score_6", score_s, 6);
    step(4600);
    check("sat_score_255", score_s, 255);
    step(40);
    check("sat_score_hold", score_s, 255);
    check("sat_no_lost", lost_s, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
